// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer
//   Command-sequencing controller for an 8259-style PIC. Host bus writes are
//   synchronized, qualified by chip select, and committed on the trailing
//   (rising) edge of wr_n. Committed writes walk ICW1 -> ICW2 -> [ICW3] ->
//   [ICW4], then decode OCW1/OCW2/OCW3 in the READY state.
//
// Parameters
//   SYNC_STAGES  flop stages on cs_n/wr_n/a0/din before edge detection (1..4)
//
// Optional build macro
//   PIC_SEQ_ERR_EN  adds sticky output seq_err, set by any ignored commit and
//                   cleared by ICW1 or rst. Undefined: port and logic absent.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   cs_n, wr_n        host chip select / write strobe (active low, async)
//   a0, din[7:0]      host address bit and write data (async)
//   init_done         high while in READY
//   vec_base[4:0]     ICW2[7:3]
//   sngl, ltim        ICW1 D1, D3
//   cas_cfg[7:0]      ICW3 value
//   aeoi, sfnm        ICW4 D1, D4
//   buf_ms[1:0]       ICW4 D3:D2
//   imr[7:0]          interrupt mask (OCW1), FF out of reset
//   ocw2_stb, ocw2    one-cycle strobe and last OCW2 byte
//   read_sel          status read select (0 IRR, 1 ISR)
//   poll_stb          one-cycle poll command pulse
//   smm               special mask mode
//   init_stb          one-cycle pulse on every accepted ICW1
//   seq_err           sticky sequence error (PIC_SEQ_ERR_EN only)

module pic_init_sequencer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       init_done,
  output logic [4:0] vec_base,
  output logic       sngl,
  output logic       ltim,
  output logic [7:0] cas_cfg,
  output logic       aeoi,
  output logic       sfnm,
  output logic [1:0] buf_ms,
  output logic [7:0] imr,
  output logic       ocw2_stb,
  output logic [7:0] ocw2,
  output logic       read_sel,
  output logic       poll_stb,
  output logic       smm,
  output logic       init_stb
`ifdef PIC_SEQ_ERR_EN
  ,
  output logic       seq_err
`endif
);

  typedef enum logic [2:0] {
    StUninit,
    StIcw2,
    StIcw3,
    StIcw4,
    StReady
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic [SYNC_STAGES-1:0] a0_sync_q;
  logic [7:0]             din_sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Strobes idle high so reset release never looks like a write.
      cs_sync_q <= '1;
      wr_sync_q <= '1;
      a0_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        din_sync_q[i] <= '0;
      end
    end else begin
      cs_sync_q[0]  <= cs_n;
      wr_sync_q[0]  <= wr_n;
      a0_sync_q[0]  <= a0;
      din_sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_q[i]  <= cs_sync_q[i-1];
        wr_sync_q[i]  <= wr_sync_q[i-1];
        a0_sync_q[i]  <= a0_sync_q[i-1];
        din_sync_q[i] <= din_sync_q[i-1];
      end
    end
  end

  logic       cs_s;
  logic       wr_s;
  logic       a0_s;
  logic [7:0] din_s;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign wr_s  = wr_sync_q[SYNC_STAGES-1];
  assign a0_s  = a0_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Write capture and commit
  // ---------------------------------------------------------------------------
  logic       wr_prev_q;
  logic       pend_q;
  logic       hold_a0_q;
  logic [7:0] hold_din_q;
  logic       wr_commit;

  // Commit only on a wr_n rise that follows at least one cs-qualified sample.
  assign wr_commit = pend_q & wr_s & ~wr_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prev_q  <= 1'b1;
      pend_q     <= 1'b0;
      hold_a0_q  <= 1'b0;
      hold_din_q <= 8'h00;
    end else begin
      wr_prev_q <= wr_s;
      if (!wr_s && !cs_s) begin
        pend_q     <= 1'b1;
        hold_a0_q  <= a0_s;
        hold_din_q <= din_s;
      end else if (wr_commit) begin
        pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM and configuration registers
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vec_base_q, vec_base_d;
  logic       sngl_q, sngl_d;
  logic       ltim_q, ltim_d;
  logic [7:0] cas_cfg_q, cas_cfg_d;
  logic       aeoi_q, aeoi_d;
  logic       sfnm_q, sfnm_d;
  logic [1:0] buf_ms_q, buf_ms_d;
  logic [7:0] imr_q, imr_d;
  logic       ocw2_stb_q, ocw2_stb_d;
  logic [7:0] ocw2_q, ocw2_d;
  logic       read_sel_q, read_sel_d;
  logic       poll_stb_q, poll_stb_d;
  logic       smm_q, smm_d;
  logic       init_stb_q, init_stb_d;
  logic       is_icw1;
  logic       commit_ignored;

  assign is_icw1 = ~hold_a0_q & hold_din_q[4];

  always_comb begin
    state_d        = state_q;
    ic4_d          = ic4_q;
    vec_base_d     = vec_base_q;
    sngl_d         = sngl_q;
    ltim_d         = ltim_q;
    cas_cfg_d      = cas_cfg_q;
    aeoi_d         = aeoi_q;
    sfnm_d         = sfnm_q;
    buf_ms_d       = buf_ms_q;
    imr_d          = imr_q;
    ocw2_stb_d     = 1'b0;
    ocw2_d         = ocw2_q;
    read_sel_d     = read_sel_q;
    poll_stb_d     = 1'b0;
    smm_d          = smm_q;
    init_stb_d     = 1'b0;
    commit_ignored = 1'b0;

    if (wr_commit) begin
      if (is_icw1) begin
        // ICW1 restarts initialization from any state.
        state_d    = StIcw2;
        sngl_d     = hold_din_q[1];
        ltim_d     = hold_din_q[3];
        ic4_d      = hold_din_q[0];
        imr_d      = 8'h00;
        smm_d      = 1'b0;
        read_sel_d = 1'b0;
        aeoi_d     = 1'b0;
        sfnm_d     = 1'b0;
        buf_ms_d   = 2'b00;
        cas_cfg_d  = 8'h00;
        init_stb_d = 1'b1;
      end else begin
        case (state_q)
          StUninit: begin
            commit_ignored = 1'b1;
          end
          StIcw2: begin
            if (hold_a0_q) begin
              vec_base_d = hold_din_q[7:3];
              if (!sngl_q) begin
                state_d = StIcw3;
              end else if (ic4_q) begin
                state_d = StIcw4;
              end else begin
                state_d = StReady;
              end
            end else begin
              commit_ignored = 1'b1;
            end
          end
          StIcw3: begin
            if (hold_a0_q) begin
              cas_cfg_d = hold_din_q;
              state_d   = ic4_q ? StIcw4 : StReady;
            end else begin
              commit_ignored = 1'b1;
            end
          end
          StIcw4: begin
            if (hold_a0_q) begin
              aeoi_d   = hold_din_q[1];
              buf_ms_d = hold_din_q[3:2];
              sfnm_d   = hold_din_q[4];
              state_d  = StReady;
            end else begin
              commit_ignored = 1'b1;
            end
          end
          StReady: begin
            if (hold_a0_q) begin
              imr_d = hold_din_q;
            end else if (!hold_din_q[3]) begin
              // din[4] is known 0 here, so din[4:3] == 00 selects OCW2.
              ocw2_d     = hold_din_q;
              ocw2_stb_d = 1'b1;
            end else begin
              if (hold_din_q[1]) begin
                read_sel_d = hold_din_q[0];
              end
              if (hold_din_q[2]) begin
                poll_stb_d = 1'b1;
              end
              if (hold_din_q[6]) begin
                smm_d = hold_din_q[5];
              end
            end
          end
          default: begin
            state_d = StUninit;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StUninit;
      ic4_q      <= 1'b0;
      vec_base_q <= 5'd0;
      sngl_q     <= 1'b0;
      ltim_q     <= 1'b0;
      cas_cfg_q  <= 8'h00;
      aeoi_q     <= 1'b0;
      sfnm_q     <= 1'b0;
      buf_ms_q   <= 2'b00;
      imr_q      <= 8'hFF;
      ocw2_stb_q <= 1'b0;
      ocw2_q     <= 8'h00;
      read_sel_q <= 1'b0;
      poll_stb_q <= 1'b0;
      smm_q      <= 1'b0;
      init_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ic4_q      <= ic4_d;
      vec_base_q <= vec_base_d;
      sngl_q     <= sngl_d;
      ltim_q     <= ltim_d;
      cas_cfg_q  <= cas_cfg_d;
      aeoi_q     <= aeoi_d;
      sfnm_q     <= sfnm_d;
      buf_ms_q   <= buf_ms_d;
      imr_q      <= imr_d;
      ocw2_stb_q <= ocw2_stb_d;
      ocw2_q     <= ocw2_d;
      read_sel_q <= read_sel_d;
      poll_stb_q <= poll_stb_d;
      smm_q      <= smm_d;
      init_stb_q <= init_stb_d;
    end
  end

`ifdef PIC_SEQ_ERR_EN
  logic seq_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_q <= 1'b0;
    end else if (wr_commit && is_icw1) begin
      seq_err_q <= 1'b0;
    end else if (commit_ignored) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_commit_ignored;
  assign unused_commit_ignored = commit_ignored;
`endif

  assign init_done = (state_q == StReady);
  assign vec_base  = vec_base_q;
  assign sngl      = sngl_q;
  assign ltim      = ltim_q;
  assign cas_cfg   = cas_cfg_q;
  assign aeoi      = aeoi_q;
  assign sfnm      = sfnm_q;
  assign buf_ms    = buf_ms_q;
  assign imr       = imr_q;
  assign ocw2_stb  = ocw2_stb_q;
  assign ocw2      = ocw2_q;
  assign read_sel  = read_sel_q;
  assign poll_stb  = poll_stb_q;
  assign smm       = smm_q;
  assign init_stb  = init_stb_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge; one-cycle pulses are counted by a
// monitor that samples shortly after each rising edge.

module tb_pic_init_sequencer;

  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic       init_done;
  logic [4:0] vec_base;
  logic       sngl;
  logic       ltim;
  logic [7:0] cas_cfg;
  logic       aeoi;
  logic       sfnm;
  logic [1:0] buf_ms;
  logic [7:0] imr;
  logic       ocw2_stb;
  logic [7:0] ocw2;
  logic       read_sel;
  logic       poll_stb;
  logic       smm;
  logic       init_stb;
`ifdef PIC_SEQ_ERR_EN
  logic       seq_err;
`endif

  pic_init_sequencer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .a0        (a0),
    .din       (din),
    .init_done (init_done),
    .vec_base  (vec_base),
    .sngl      (sngl),
    .ltim      (ltim),
    .cas_cfg   (cas_cfg),
    .aeoi      (aeoi),
    .sfnm      (sfnm),
    .buf_ms    (buf_ms),
    .imr       (imr),
    .ocw2_stb  (ocw2_stb),
    .ocw2      (ocw2),
    .read_sel  (read_sel),
    .poll_stb  (poll_stb),
    .smm       (smm),
    .init_stb  (init_stb)
`ifdef PIC_SEQ_ERR_EN
    ,
    .seq_err   (seq_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ocw2_cnt = 0;
  int poll_cnt = 0;
  int init_cnt = 0;
  int exp_ocw2 = 0;
  int exp_poll = 0;
  int exp_init = 0;

  always @(posedge clk) begin
    #1;
    if (ocw2_stb === 1'b1) ocw2_cnt++;
    if (poll_stb === 1'b1) poll_cnt++;
    if (init_stb === 1'b1) init_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full host write: wr_n low for two clocks, then enough idle clocks for commit.
  task automatic host_write(input logic addr, input logic [7:0] data);
    @(negedge clk);
    cs_n = 1'b0;
    a0   = addr;
    din  = data;
    wr_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
  endtask

  task automatic check_pulses(input string tag);
    check_eq({tag, "_ocw2_cnt"}, ocw2_cnt, exp_ocw2);
    check_eq({tag, "_poll_cnt"}, poll_cnt, exp_poll);
    check_eq({tag, "_init_cnt"}, init_cnt, exp_init);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    cs_n = 1'b1;
    wr_n = 1'b1;
    a0   = 1'b0;
    din  = 8'h00;
    do_reset();

    // Reset state
    check_eq("rst_imr", imr, 8'hFF);
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_vec_base", vec_base, 5'h00);
    check_eq("rst_cfg", {sngl, ltim, aeoi, sfnm, buf_ms, read_sel, smm}, 8'h00);
    check_eq("rst_ocw2_cas", {ocw2, cas_cfg}, 16'h0000);
`ifdef PIC_SEQ_ERR_EN
    check_eq("rst_seq_err", seq_err, 1'b0);
`endif
    check_pulses("rst");

    // 1. Single mode with ICW4
    host_write(1'b0, 8'h13);
    exp_init++;
    check_eq("t1_icw1_imr", imr, 8'h00);
    check_eq("t1_icw1_sngl", sngl, 1'b1);
    check_eq("t1_icw1_not_done", init_done, 1'b0);
    check_pulses("t1_icw1");
    host_write(1'b1, 8'h40);
    check_eq("t1_vec_base", vec_base, 5'h08);
    check_eq("t1_icw2_not_done", init_done, 1'b0);
    host_write(1'b1, 8'h03);
    check_eq("t1_aeoi", aeoi, 1'b1);
    check_eq("t1_buf_sfnm", {buf_ms, sfnm}, 3'b000);
    check_eq("t1_done", init_done, 1'b1);
    check_eq("t1_cas_skipped", cas_cfg, 8'h00);
    check_eq("t1_imr", imr, 8'h00);

    // 2. Cascade mode with ICW3 and ICW4
    host_write(1'b0, 8'h11);
    exp_init++;
    check_eq("t2_sngl", sngl, 1'b0);
    host_write(1'b1, 8'h20);
    check_eq("t2_vec_base", vec_base, 5'h04);
    check_eq("t2_icw2_not_done", init_done, 1'b0);
    host_write(1'b1, 8'h04);
    check_eq("t2_cas_cfg", cas_cfg, 8'h04);
    check_eq("t2_icw3_not_done", init_done, 1'b0);
    host_write(1'b1, 8'h01);
    check_eq("t2_aeoi", aeoi, 1'b0);
    check_eq("t2_done", init_done, 1'b1);
    check_pulses("t2");

    // 3. Operational commands
    host_write(1'b1, 8'hA5);
    check_eq("t3_imr", imr, 8'hA5);
    host_write(1'b0, 8'h20);
    exp_ocw2++;
    check_eq("t3_ocw2", ocw2, 8'h20);
    check_pulses("t3_ocw2");
    host_write(1'b0, 8'h0B);
    check_eq("t3_read_sel", read_sel, 1'b1);
    host_write(1'b0, 8'h0C);
    exp_poll++;
    check_eq("t3_read_sel_kept", read_sel, 1'b1);
    check_eq("t3_smm_kept", smm, 1'b0);
    check_pulses("t3_poll");
    host_write(1'b0, 8'h68);
    check_eq("t3_smm", smm, 1'b1);
    check_eq("t3_imr_kept", imr, 8'hA5);
    check_pulses("t3_end");

    // 4. Restart from ICW3, ignored write mid-sequence, then reset
    host_write(1'b0, 8'h11);
    exp_init++;
    host_write(1'b1, 8'h20);
    host_write(1'b0, 8'h05);
    check_eq("t4_ignored_ocw2", ocw2, 8'h20);
    check_eq("t4_ignored_not_done", init_done, 1'b0);
    check_pulses("t4_ignored");
`ifdef PIC_SEQ_ERR_EN
    check_eq("t4_seq_err_set", seq_err, 1'b1);
`endif
    host_write(1'b0, 8'h13);
    exp_init++;
    check_eq("t4_restart_imr", imr, 8'h00);
    check_eq("t4_restart_cas", cas_cfg, 8'h00);
    check_eq("t4_restart_smm_rs", {smm, read_sel}, 2'b00);
    check_eq("t4_restart_sngl", sngl, 1'b1);
    check_pulses("t4_restart");
`ifdef PIC_SEQ_ERR_EN
    check_eq("t4_seq_err_clr", seq_err, 1'b0);
`endif
    host_write(1'b1, 8'h40);
    check_eq("t4_vec_base", vec_base, 5'h08);
    check_eq("t4_in_icw4", init_done, 1'b0);
    do_reset();
    check_eq("t4_rst_imr", imr, 8'hFF);
    check_eq("t4_rst_done", init_done, 1'b0);
    check_eq("t4_rst_vec", vec_base, 5'h00);

    // 6. Ignored write before ICW1
    host_write(1'b1, 8'h55);
    check_eq("t6_uninit_imr", imr, 8'hFF);
    check_eq("t6_uninit_done", init_done, 1'b0);
`ifdef PIC_SEQ_ERR_EN
    check_eq("t6_seq_err_set", seq_err, 1'b1);
`endif
    host_write(1'b0, 8'h1A);
    exp_init++;
    check_eq("t6_ltim_sngl", {ltim, sngl}, 2'b11);
`ifdef PIC_SEQ_ERR_EN
    check_eq("t6_seq_err_clr", seq_err, 1'b0);
`endif
    host_write(1'b1, 8'hF8);
    check_eq("t6_vec_base", vec_base, 5'h1F);
    check_eq("t6_done_no_icw4", init_done, 1'b1);

    // 5. wr_n pulse with cs_n high is ignored
    @(negedge clk);
    a0   = 1'b1;
    din  = 8'h77;
    wr_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_n = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    check_eq("t5_no_cs_imr", imr, 8'h00);

    // 5. One-cycle strobe: update exactly SYNC_STAGES+1 clocks after the rise
    @(negedge clk);
    cs_n = 1'b0;
    a0   = 1'b1;
    din  = 8'h3C;
    wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      @(negedge clk);
      if (k <= SYNC_STAGES) check_eq("t5_early_imr", imr, 8'h00);
      else check_eq("t5_on_time_imr", imr, 8'h3C);
    end
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_single_update", imr, 8'h3C);
    check_pulses("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
